countdown_timer: RTL
====================

# countdown_timer

Loadable down-counting timer, the counterpart to the team's free-running 8-bit up-counter. It loads a start value, decrements once per clock to zero, signals completion with a one-cycle `done` pulse, then optionally reloads. It sits beside the up-counter in the timing/counter library and serves as the programmable delay and interval generator for downstream control logic.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: load-and-run request; sampled only in IDLE.
- `load_val` in WIDTH: start/reload value; sampled with `start`.
- `pause` in 1: level; while high in RUN or HOLD, counting is suspended.
- `abort` in 1: level; cancels an active count.
- `auto_reload` in 1: sampled on the terminal-count edge; 1 means reload and keep running.
- `cnt` out WIDTH: current count, registered.
- `busy` out 1: high when state is not IDLE (RUN or HOLD).
- `done` out 1: registered one-cycle pulse on terminal count.

## Operation
- States: IDLE, RUN, HOLD. Use an internal `reload` register of WIDTH bits.
- Priority within an active state: abort, then pause, then decrement.
- IDLE:
  - `start=1` with `load_val!=0`: `cnt<=load_val`, `reload<=load_val`, go to RUN.
  - `start=1` with `load_val==0`: `done<=1` for one cycle, `cnt` stays 0, remain IDLE, `busy` stays 0.
  - Otherwise hold. `abort` and `pause` have no effect in IDLE.
- RUN:
  - `abort=1`: `cnt<=0`, go to IDLE, no `done`.
  - Else `pause=1`: go to HOLD, `cnt` unchanged.
  - Else if `cnt==1` (terminal): `done<=1`. If `auto_reload=1`, `cnt<=reload` and stay in RUN. Else `cnt<=0` and go to IDLE.
  - Else `cnt<=cnt-1`.
  - `start` is ignored in RUN and HOLD, and `load_val` is not resampled.
- HOLD:
  - `abort=1`: `cnt<=0`, go to IDLE.
  - Else `pause=0`: go to RUN with no decrement on that edge.
  - Else hold.
- `done` is 0 on every edge that is not a terminal edge or a zero-load start.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement never passes below 0, because the terminal check at 1 prevents underflow. `load_val` of all-ones (255 for WIDTH=8) is legal and runs 255 cycles.

## Timing
- Reset (asynchronous, any time, including mid-count): `cnt=0`, `busy=0`, `done=0`, state IDLE, `reload=0`. Outputs clear immediately on `rst_n` falling, with no clock edge needed. The first `start` is accepted on the first rising edge after `rst_n` rises.
- `start` sampled at edge k with N≥1:
  - `cnt=N` and `busy=1` after edge k.
  - `cnt=N-j` after edge k+j.
  - `done=1` and `cnt=0` after edge k+N, with `busy=0` (no reload).
  - `done` clears after edge k+N+1.
- A new `start` is accepted at edge k+N+1 at the earliest, which gives an N+1-cycle minimum period for back-to-back one-shots.
- Auto-reload gives a period of exactly N cycles between `done` pulses. `busy` stays 1 and `cnt` goes N, …, 1, N, …
- Each cycle spent in HOLD, plus the resume edge, extends time-to-`done` by one cycle.
- `abort` takes effect on the edge it is sampled. If `abort` coincides with `cnt==1`, `abort` wins and `done` stays 0.
- Pause plus terminal on the same edge: pause wins, `cnt` stays 1, and `done` fires on the first RUN edge after resume.

## Test plan
- Reset, then `start` with `load_val=5`, no pause. Expect `cnt` 5,4,3,2,1,0 over edges k..k+5, `done` high only after k+5, `busy` high for edges k..k+4, and `busy=0` after k+5.
- `load_val=0` with `start`. Expect `done` pulse for one cycle, `busy` never 1, `cnt` stays 0.
- `load_val=3` with `auto_reload=1` held for 3 periods. Expect `cnt` 3,2,1,3,2,1,3,2,1, `done` every 3rd cycle, `busy` constantly 1. Drop `auto_reload`; expect a final `done` with `cnt=0` and IDLE.
- `load_val=4`, `pause` high for 2 cycles while `cnt=2`. Expect `cnt` held at 2 for those cycles plus the resume edge, then 1,0, with `done` 3 cycles later than the unpaused case.
- `abort` while `cnt=1`. Expect `cnt=0`, `busy=0`, no `done`. `start` pulsed mid-RUN has no effect on `cnt`.
- `rst_n` asserted asynchronously at `cnt=100` of a 200 load. Expect immediate `cnt=0`, `busy=0`, `done=0`. Then `start` with `load_val=255` counts the full 255 cycles with no underflow.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counting timer. A start in IDLE loads load_val, the count
//   then decrements once per clock to zero, and a one-cycle done pulse marks
//   the terminal count. With auto_reload high at the terminal edge the timer
//   reloads the captured start value and keeps running.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   start       - load-and-run request, sampled only in IDLE
//   load_val    - start/reload value, sampled with start
//   pause       - level, suspends counting in RUN/HOLD
//   abort       - level, cancels an active count (no done)
//   auto_reload - sampled on the terminal edge; 1 = reload and keep running
//   cnt         - current count (registered)
//   busy        - high in RUN or HOLD
//   done        - registered one-cycle terminal-count pulse
module countdown_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Priority in active states: abort, then pause, then decrement/terminal.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        cnt_d    = load_val;
                        reload_d = load_val;
                        state_d  = RUN;
                    end else begin
                        // Zero-length request completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (cnt_q == ONE) begin
                    // Terminal at 1 so the count never wraps below zero.
                    done_d = 1'b1;
                    if (auto_reload) begin
                        cnt_d = reload_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            HOLD: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    // Resume edge does not decrement.
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt  = cnt_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
